// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the IF/MEM request ports and the byte-wide RAM bus of mem_ctrl.
// Latency: none, wires only.
// Backpressure: carried by the req/done handshakes and io_buffer_full.
interface mem_ctrl_if;
  // instruction fetch side
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_done;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  // load/store side
  logic        data_req;
  logic        data_we;
  logic [2:0]  data_len;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;
  // UART status and RAM bus
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  // pipeline + RAM environment side
  modport master (
    output inst_req, inst_addr, data_req, data_we, data_len, data_addr, data_wdata,
    output io_buffer_full, mem_din,
    input  inst_done, inst_o, inst_pc, data_done, data_rdata, mem_dout, mem_a, mem_wr
  );

  // controller side
  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_len, data_addr, data_wdata,
    input  io_buffer_full, mem_din,
    output inst_done, inst_o, inst_pc, data_done, data_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM sequencer arbitrating IF fetches against MEM loads/stores.
// Latency: reads finish len+1 cycles after acceptance, writes len cycles (+1 per I/O stall cycle).
// Backpressure: requests wait until IDLE/DONE; I/O-region stores hold in IOWAIT while io_buffer_full.
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_IOWAIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state;
  logic        owner_data;  // 1 = transaction belongs to MEM, 0 = IF
  logic [31:0] base_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt;         // READ: edges since acceptance; WRITE/IOWAIT: next byte index
  logic [31:0] wdata_q;
  logic [31:0] rbuf;        // bytes captured so far; cleared on acceptance so short loads zero-extend

  logic        accept_data;
  logic        accept_inst;
  logic [31:0] byte_addr;
  logic        cur_io;
  logic        new_io;
  logic [7:0]  wbyte;
  logic [1:0]  rd_slot;
  logic [31:0] asm_word;

  // Arbitration: a new request may be taken in IDLE or on the edge that ends the done
  // cycle. In DONE the owner is dropping its req, so only the other requester is eligible.
  always_comb begin
    accept_data = bus.data_req &&
                  ((state == S_IDLE) || ((state == S_DONE) && !owner_data));
    accept_inst = bus.inst_req && !accept_data &&
                  ((state == S_IDLE) || ((state == S_DONE) && owner_data));
  end

  // Byte addressing, write byte select and read assembly for the current step.
  always_comb begin
    byte_addr = base_q + {29'd0, cnt};
    cur_io    = (byte_addr[17:16] == 2'b11);
    new_io    = (bus.data_addr[17:16] == 2'b11);
    case (cnt[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
    // mem_din arriving at edge k+c belongs to the address issued at edge k+c-2
    rd_slot  = cnt[1:0] - 2'd2;
    asm_word = rbuf;
    asm_word[{rd_slot, 3'b000} +: 8] = bus.mem_din;
  end

  // Transaction sequencer: acceptance, byte issue/capture, I/O stall and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      owner_data     <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      cnt            <= '0;
      wdata_q        <= '0;
      rbuf           <= '0;
      bus.mem_wr     <= 1'b0;
      bus.mem_dout   <= '0;
      bus.mem_a      <= '0;
      bus.inst_done  <= 1'b0;
      bus.data_done  <= 1'b0;
      bus.inst_o     <= '0;
      bus.inst_pc    <= '0;
      bus.data_rdata <= '0;
    end else begin
      bus.inst_done <= 1'b0;
      bus.data_done <= 1'b0;
      bus.mem_wr    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept_data) begin
            owner_data <= 1'b1;
            base_q     <= bus.data_addr;
            len_q      <= bus.data_len;
            wdata_q    <= bus.data_wdata;
            rbuf       <= '0;
            bus.mem_a  <= bus.data_addr;
            if (bus.data_we) begin
              if (new_io && bus.io_buffer_full) begin
                cnt   <= 3'd0;
                state <= S_IOWAIT;
              end else begin
                bus.mem_dout <= bus.data_wdata[7:0];
                bus.mem_wr   <= 1'b1;
                cnt          <= 3'd1;
                state        <= S_WRITE;
              end
            end else begin
              cnt   <= 3'd1;
              state <= S_READ;
            end
          end else if (accept_inst) begin
            owner_data <= 1'b0;
            base_q     <= bus.inst_addr;
            len_q      <= 3'd4;
            rbuf       <= '0;
            bus.mem_a  <= bus.inst_addr;
            cnt        <= 3'd1;
            state      <= S_READ;
          end else begin
            state <= S_IDLE;
          end
        end

        S_READ: begin
          if (cnt < len_q) begin
            bus.mem_a <= byte_addr;
          end
          if (cnt >= 3'd2) begin
            rbuf <= asm_word;
          end
          if (cnt == len_q + 3'd1) begin
            state <= S_DONE;
            if (owner_data) begin
              bus.data_rdata <= asm_word;
              bus.data_done  <= 1'b1;
            end else begin
              bus.inst_o    <= asm_word;
              bus.inst_pc   <= base_q;
              bus.inst_done <= 1'b1;
            end
          end
          cnt <= cnt + 3'd1;
        end

        S_WRITE: begin
          if (cnt == len_q) begin
            bus.data_done <= 1'b1;
            state         <= S_DONE;
          end else if (cur_io && bus.io_buffer_full) begin
            state <= S_IOWAIT;
          end else begin
            bus.mem_a    <= byte_addr;
            bus.mem_dout <= wbyte;
            bus.mem_wr   <= 1'b1;
            cnt          <= cnt + 3'd1;
          end
        end

        S_IOWAIT: begin
          if (!bus.io_buffer_full) begin
            bus.mem_a    <= byte_addr;
            bus.mem_dout <= wbyte;
            bus.mem_wr   <= 1'b1;
            cnt          <= cnt + 3'd1;
            state        <= S_WRITE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed tests of mem_ctrl against a byte RAM with 1-cycle read latency.
// Latency: n/a (testbench).
// Backpressure: drives io_buffer_full directly to exercise the I/O stall.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  mem_ctrl_if bus ();

  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // RAM model: synchronous read, write on the edge where mem_wr is high
  logic [7:0] ram [bit [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end

  // done-pulse monitor (high cycles of each done signal)
  int n_ip = 0;
  int n_dp = 0;
  always @(negedge clk) begin
    if (bus.inst_done) n_ip++;
    if (bus.data_done) n_dp++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // per-transaction trace, indexed by edges since acceptance
  int          inst_e;
  int          data_e;
  int          w_e[$];
  logic [31:0] w_a[$];
  logic [7:0]  w_d[$];
  logic [31:0] a_tr[$];

  // Caller has driven the request(s) after a negedge; the next posedge accepts.
  task automatic run_txn(input int drop_full_at);
    int e;
    e = 0;
    inst_e = -1;
    data_e = -1;
    w_e.delete(); w_a.delete(); w_d.delete(); a_tr.delete();
    @(posedge clk);
    while (e < 60) begin
      @(negedge clk);
      a_tr.push_back(bus.mem_a);
      if (bus.mem_wr) begin
        w_e.push_back(e);
        w_a.push_back(bus.mem_a);
        w_d.push_back(bus.mem_dout);
      end
      if (bus.inst_done) begin inst_e = e; bus.inst_req = 1'b0; end
      if (bus.data_done) begin data_e = e; bus.data_req = 1'b0; end
      if (e == drop_full_at) bus.io_buffer_full = 1'b0;
      if (!bus.inst_req && !bus.data_req) break;
      @(posedge clk);
      e++;
    end
    check("txn_complete", {31'd0, bus.inst_req | bus.data_req}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int ip0;
  int dp0;
  logic [31:0] exp_tr [12];
  logic [7:0]  st_bytes [4];

  initial begin
    bus.inst_req = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_we = 0; bus.data_len = 0;
    bus.data_addr = 0; bus.data_wdata = 0; bus.io_buffer_full = 0;
    rst = 1'b1;

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h2001] = 8'hAB; ram[32'h2002] = 8'hCD;
    ram[32'h500] = 8'h11; ram[32'h501] = 8'h22; ram[32'h502] = 8'h33; ram[32'h503] = 8'h44;
    ram[32'h600] = 8'h93; ram[32'h601] = 8'h00; ram[32'h602] = 8'h10; ram[32'h603] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst_done", {31'd0, bus.inst_done}, 32'd0);
    check("rst_data_done", {31'd0, bus.data_done}, 32'd0);
    check("rst_mem_wr",    {31'd0, bus.mem_wr}, 32'd0);
    check("rst_mem_a",     bus.mem_a, 32'd0);
    check("rst_mem_dout",  {24'd0, bus.mem_dout}, 32'd0);
    check("rst_inst_o",    bus.inst_o, 32'd0);
    check("rst_inst_pc",   bus.inst_pc, 32'd0);
    check("rst_rdata",     bus.data_rdata, 32'd0);
    rst = 1'b0;

    // fetch 0x100
    ip0 = n_ip; dp0 = n_dp;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
    run_txn(-1);
    check("fetch_latency", inst_e, 5);
    check("fetch_inst_o",  bus.inst_o, 32'h0000_0513);
    check("fetch_inst_pc", bus.inst_pc, 32'h100);
    check("fetch_no_wr",   w_e.size(), 0);
    idle_cycles(3);
    check("fetch_ipulses", n_ip - ip0, 1);
    check("fetch_dpulses", n_dp - dp0, 0);

    // 2-byte load at 0x2001
    ip0 = n_ip; dp0 = n_dp;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_len = 3'd2; bus.data_addr = 32'h2001;
    run_txn(-1);
    check("ld2_latency", data_e, 3);
    check("ld2_rdata",   bus.data_rdata, 32'h0000_CDAB);
    idle_cycles(3);
    check("ld2_dpulses", n_dp - dp0, 1);
    check("ld2_ipulses", n_ip - ip0, 0);
    check("ld2_hold_rdata", bus.data_rdata, 32'h0000_CDAB);

    // 4-byte store at 0x3000
    st_bytes[0] = 8'hEF; st_bytes[1] = 8'hBE; st_bytes[2] = 8'hAD; st_bytes[3] = 8'hDE;
    dp0 = n_dp;
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_len = 3'd4;
    bus.data_addr = 32'h3000; bus.data_wdata = 32'hDEAD_BEEF;
    run_txn(-1);
    check("st4_nwrites", w_e.size(), 4);
    for (int i = 0; i < 4 && i < w_e.size(); i++) begin
      check($sformatf("st4_wr%0d_cyc", i), w_e[i], i);
      check($sformatf("st4_wr%0d_addr", i), w_a[i], 32'h3000 + i);
      check($sformatf("st4_wr%0d_dat", i), {24'd0, w_d[i]}, {24'd0, st_bytes[i]});
    end
    check("st4_latency", data_e, 4);
    check("st4_ram", {ram_rd(32'h3003), ram_rd(32'h3002), ram_rd(32'h3001), ram_rd(32'h3000)},
          32'hDEAD_BEEF);
    idle_cycles(3);
    check("st4_dpulses", n_dp - dp0, 1);

    // simultaneous load (0x500, 4 bytes) and fetch (0x600)
    exp_tr = '{32'h500, 32'h501, 32'h502, 32'h503, 32'h503, 32'h503,
               32'h600, 32'h601, 32'h602, 32'h603, 32'h603, 32'h603};
    ip0 = n_ip; dp0 = n_dp;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_len = 3'd4; bus.data_addr = 32'h500;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h600;
    run_txn(-1);
    check("arb_data_first", data_e, 5);
    check("arb_inst_after", inst_e, 11);
    check("arb_rdata",   bus.data_rdata, 32'h4433_2211);
    check("arb_inst_o",  bus.inst_o, 32'h0010_0093);
    check("arb_inst_pc", bus.inst_pc, 32'h600);
    check("arb_trace_len", a_tr.size(), 12);
    for (int i = 0; i < 12 && i < a_tr.size(); i++)
      check($sformatf("arb_mem_a_e%0d", i), a_tr[i], exp_tr[i]);
    idle_cycles(3);
    check("arb_ipulses", n_ip - ip0, 1);
    check("arb_dpulses", n_dp - dp0, 1);

    // 1-byte store to I/O region with the UART buffer full for 3 cycles
    bus.io_buffer_full = 1'b1;
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_len = 3'd1;
    bus.data_addr = 32'h3_0000; bus.data_wdata = 32'h0000_005A;
    run_txn(2);
    check("io_nwrites", w_e.size(), 1);
    if (w_e.size() > 0) begin
      check("io_wr_cyc",  w_e[0], 3);
      check("io_wr_addr", w_a[0], 32'h3_0000);
      check("io_wr_dat",  {24'd0, w_d[0]}, 32'h5A);
    end
    check("io_latency", data_e, 4);

    // reset during the third byte of a fetch
    idle_cycles(2);
    ip0 = n_ip;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_third_addr", bus.mem_a, 32'h102);
    rst = 1'b1;
    bus.inst_req = 1'b0;
    @(negedge clk);
    check("abort_mem_wr",  {31'd0, bus.mem_wr}, 32'd0);
    check("abort_mem_a",   bus.mem_a, 32'd0);
    check("abort_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    check("abort_inst_o",  bus.inst_o, 32'd0);
    check("abort_inst_pc", bus.inst_pc, 32'd0);
    check("abort_rdata",   bus.data_rdata, 32'd0);
    check("abort_done", {30'd0, bus.inst_done, bus.data_done}, 32'd0);
    rst = 1'b0;
    idle_cycles(8);
    check("abort_no_pulse", n_ip - ip0, 0);

    bus.inst_req = 1'b1; bus.inst_addr = 32'h600;
    run_txn(-1);
    check("refetch_latency", inst_e, 5);
    check("refetch_inst_o",  bus.inst_o, 32'h0010_0093);
    check("refetch_inst_pc", bus.inst_pc, 32'h600);
    idle_cycles(2);
    check("refetch_ipulses", n_ip - ip0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
